// File: rtl/instr_mem_loader_pkg.sv
// Shared definitions for the instruction-memory loader: FSM state encoding and the
// byte-order constant that the fetch path's opcode/data demux also relies on.
package instr_mem_loader_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ACCEPT  = 3'd1,
        WR_OP   = 3'd2,
        WR_DATA = 3'd3,
        DONE    = 3'd4,
        ERR     = 3'd5
    } state_t;

    // Opcode byte lives at the address whose LSB equals this value; data at the other one.
    localparam int OPCODE_ADDR_LSB = 0;

    function automatic logic is_busy(input state_t s);
        return (s == ACCEPT) || (s == WR_OP) || (s == WR_DATA);
    endfunction

endpackage

// File: rtl/instr_mem_loader_addr_ctr.sv
// Pair pointer for the loader: always even, advances by 2 per pair, wraps at the top.
// Presents both byte addresses of the current pair and flags the last pair slot.
module instr_mem_loader_addr_ctr #(
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clr,
    input  logic                  inc,
    output logic [ADDR_WIDTH-1:0] ptr_even,
    output logic [ADDR_WIDTH-1:0] ptr_odd,
    output logic                  at_top
);

    localparam logic [ADDR_WIDTH-1:0] TOP_PAIR = {{(ADDR_WIDTH-1){1'b1}}, 1'b0};

    logic [ADDR_WIDTH-1:0] ptr_q;

    // NOTE: flops use non-blocking assignments so every register samples pre-edge values,
    // and reset sits in the sensitivity list so it acts without a clock.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= '0;
        end else if (clr) begin
            ptr_q <= '0;
        end else if (inc) begin
            ptr_q <= ptr_q + ADDR_WIDTH'(2);
        end
    end

    assign ptr_even = ptr_q;
    assign ptr_odd  = ptr_q | ADDR_WIDTH'(1);
    assign at_top   = (ptr_q == TOP_PAIR);

endmodule

// File: rtl/instr_mem_loader.sv
// Writes (opcode, data) pairs from a valid/ready source into instruction memory as two
// consecutive bytes, opcode at the even address, one pair every three cycles.
module instr_mem_loader
    import instr_mem_loader_pkg::*;
#(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  instr_mem_loader_clk,
    input  logic                  instr_mem_loader_rst,
    input  logic                  instr_mem_loader_start,
    input  logic                  instr_mem_loader_in_valid,
    output logic                  instr_mem_loader_in_ready,
    input  logic [DATA_WIDTH-1:0] instr_mem_loader_in_opcode,
    input  logic [DATA_WIDTH-1:0] instr_mem_loader_in_data,
    input  logic                  instr_mem_loader_in_last,
    output logic                  instr_mem_loader_mem_wr_en,
    output logic [ADDR_WIDTH-1:0] instr_mem_loader_mem_addr,
    output logic [DATA_WIDTH-1:0] instr_mem_loader_mem_wdata,
    output logic [ADDR_WIDTH-1:0] instr_mem_loader_pair_count,
    output logic                  instr_mem_loader_busy,
    output logic                  instr_mem_loader_done,
    output logic                  instr_mem_loader_overflow
);

    state_t state_q, state_d;

    logic [DATA_WIDTH-1:0] data_q;
    logic                  last_q;
    logic                  fire;
    logic                  ptr_clr, ptr_inc;
    logic [ADDR_WIDTH-1:0] ptr_even, ptr_odd;
    logic [ADDR_WIDTH-1:0] op_addr, data_addr;
    logic                  at_top;

    instr_mem_loader_addr_ctr #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_addr_ctr (
        .clk      (instr_mem_loader_clk),
        .rst_n    (instr_mem_loader_rst),
        .clr      (ptr_clr),
        .inc      (ptr_inc),
        .ptr_even (ptr_even),
        .ptr_odd  (ptr_odd),
        .at_top   (at_top)
    );

    assign op_addr   = (OPCODE_ADDR_LSB == 0) ? ptr_even : ptr_odd;
    assign data_addr = (OPCODE_ADDR_LSB == 0) ? ptr_odd  : ptr_even;

    // in_ready is registered from the next state, so it is high exactly while in ACCEPT.
    assign fire = (state_q == ACCEPT) && instr_mem_loader_in_valid && instr_mem_loader_in_ready;

    // NOTE: every signal written here gets a default first; a path that skipped an
    // assignment would otherwise infer a latch.
    always_comb begin
        state_d = state_q;
        ptr_clr = 1'b0;
        ptr_inc = 1'b0;
        unique case (state_q)
            IDLE, DONE, ERR: begin
                if (instr_mem_loader_start) begin
                    state_d = ACCEPT;
                    ptr_clr = 1'b1;
                end
            end
            ACCEPT: begin
                if (fire) state_d = WR_OP;
            end
            WR_OP: begin
                state_d = WR_DATA;
            end
            WR_DATA: begin
                ptr_inc = 1'b1;
                if (last_q)      state_d = DONE;
                else if (at_top) state_d = ERR;
                else             state_d = ACCEPT;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge instr_mem_loader_clk or negedge instr_mem_loader_rst) begin
        if (!instr_mem_loader_rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // The opcode goes straight to the write port on the handshake edge, so only data/last are held.
    always_ff @(posedge instr_mem_loader_clk or negedge instr_mem_loader_rst) begin
        if (!instr_mem_loader_rst) begin
            data_q <= '0;
            last_q <= 1'b0;
        end else if (fire) begin
            data_q <= instr_mem_loader_in_data;
            last_q <= instr_mem_loader_in_last;
        end
    end

    // Outputs are registered from the next state so they line up with the state they describe.
    always_ff @(posedge instr_mem_loader_clk or negedge instr_mem_loader_rst) begin
        if (!instr_mem_loader_rst) begin
            instr_mem_loader_in_ready  <= 1'b0;
            instr_mem_loader_busy      <= 1'b0;
            instr_mem_loader_done      <= 1'b0;
            instr_mem_loader_overflow  <= 1'b0;
            instr_mem_loader_mem_wr_en <= 1'b0;
            instr_mem_loader_mem_addr  <= '0;
            instr_mem_loader_mem_wdata <= '0;
        end else begin
            instr_mem_loader_in_ready  <= (state_d == ACCEPT);
            instr_mem_loader_busy      <= is_busy(state_d);
            instr_mem_loader_done      <= (state_d == DONE);
            instr_mem_loader_overflow  <= (state_d == ERR);
            instr_mem_loader_mem_wr_en <= (state_d == WR_OP) || (state_d == WR_DATA);
            unique case (state_d)
                WR_OP: begin
                    instr_mem_loader_mem_addr  <= op_addr;
                    instr_mem_loader_mem_wdata <= instr_mem_loader_in_opcode;
                end
                WR_DATA: begin
                    instr_mem_loader_mem_addr  <= data_addr;
                    instr_mem_loader_mem_wdata <= data_q;
                end
                default: begin
                    instr_mem_loader_mem_addr  <= '0;
                    instr_mem_loader_mem_wdata <= '0;
                end
            endcase
        end
    end

    always_ff @(posedge instr_mem_loader_clk or negedge instr_mem_loader_rst) begin
        if (!instr_mem_loader_rst) begin
            instr_mem_loader_pair_count <= '0;
        end else if (ptr_clr) begin
            instr_mem_loader_pair_count <= '0;
        end else if (ptr_inc) begin
            instr_mem_loader_pair_count <= instr_mem_loader_pair_count + ADDR_WIDTH'(1);
        end
    end

endmodule
